// File: rtl/perf_counter_bank.sv
// Event-counter bank: NUM_CH saturating event counters plus an active-cycle counter,
// frozen on processor halt, read through a registered single-cycle request/response port.
module perf_counter_bank #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned CYC_W  = 32,
  parameter int unsigned SEL_W  = 5,
  localparam int unsigned MAX_CW = (CNT_W > CYC_W) ? CNT_W : CYC_W,
  localparam int unsigned DATA_W = (MAX_CW > NUM_CH) ? MAX_CW : NUM_CH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              halt,
  input  logic [NUM_CH-1:0] evt,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              frozen,
  output logic [NUM_CH-1:0] ovf
);

  typedef enum logic [1:0] {IDLE, COUNT, FROZEN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CYC_W-1:0] cyc;
  logic [DATA_W-1:0] sel_data_c;
  logic             sel_err_c;

  // Read select mux over the current (pre-update) register values.
  always_comb begin
    sel_data_c = '0;
    sel_err_c  = 1'b0;
    if (rd_sel == SEL_W'(NUM_CH)) begin
      sel_data_c = DATA_W'(cyc);
    end else if (rd_sel == SEL_W'(NUM_CH + 1)) begin
      sel_data_c = DATA_W'(ovf);
    end else if (32'(rd_sel) > NUM_CH + 1) begin
      sel_err_c = 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_sel == SEL_W'(i)) sel_data_c = DATA_W'(cnt[i]);
      end
    end
  end

  // Control FSM and counters; clr overrides events and halt in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      frozen <= 1'b0;
      cyc    <= '0;
      ovf    <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else if (clr) begin
      state  <= IDLE;
      frozen <= 1'b0;
      cyc    <= '0;
      ovf    <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      if (state == COUNT) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (evt[i]) begin
            if (cnt[i] == '1) ovf[i] <= 1'b1;
            else              cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
        if (cyc != '1) cyc <= cyc + CYC_W'(1);
      end
      case (state)
        IDLE, COUNT: begin
          if (halt) begin
            state  <= FROZEN;
            frozen <= 1'b1;
          end else begin
            state <= en ? COUNT : IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered read response, valid exactly one cycle after the request edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_data  <= rd_req ? sel_data_c : '0;
      rd_err   <= rd_req & sel_err_c;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: directed plan steps plus a randomized phase,
// all checked against a cycle-level behavioural model of the counting rules.
module tb_perf_counter_bank;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CYC_W  = 10;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned DATA_W = 10;
  localparam int CNT_MAX = 255;
  localparam int CYC_MAX = 1023;
  localparam int M_IDLE = 0, M_COUNT = 1, M_FROZEN = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0, clr = 1'b0, halt = 1'b0, rd_req = 1'b0;
  logic [NUM_CH-1:0] evt = '0;
  logic [SEL_W-1:0]  rd_sel = '0;
  logic              rd_valid, rd_err, frozen;
  logic [DATA_W-1:0] rd_data;
  logic [NUM_CH-1:0] ovf;

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CYC_W(CYC_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .halt(halt), .evt(evt),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_err(rd_err), .frozen(frozen), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model: plain counts and a mode number
  int          m_cnt [NUM_CH];
  int          m_cyc;
  logic [7:0]  m_ovf;
  int          m_mode;
  logic        e_valid, e_err;
  logic [31:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    m_cyc = 0;
    m_ovf = '0;
    m_mode = M_IDLE;
  endtask

  // One clock: predict response from pre-edge model, advance model, then compare.
  task automatic tick();
    int s;
    s = int'(rd_sel);
    e_valid = rd_req;
    e_err = 1'b0;
    e_data = 32'd0;
    if (rd_req) begin
      if (s < NUM_CH)            e_data = 32'(m_cnt[s]);
      else if (s == NUM_CH)      e_data = 32'(m_cyc);
      else if (s == NUM_CH + 1)  e_data = 32'(m_ovf);
      else                       e_err = 1'b1;
    end
    if (clr) begin
      model_clear();
    end else begin
      if (m_mode == M_COUNT) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (evt[i]) begin
            if (m_cnt[i] == CNT_MAX) m_ovf[i] = 1'b1;
            else m_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (m_cyc < CYC_MAX) m_cyc = m_cyc + 1;
      end
      if (m_mode != M_FROZEN) begin
        if (halt) m_mode = M_FROZEN;
        else m_mode = en ? M_COUNT : M_IDLE;
      end
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(e_valid));
    chk("rd_data", 32'(rd_data), e_data);
    chk("rd_err", 32'(rd_err), 32'(e_err));
    chk("frozen", 32'(frozen), 32'(m_mode == M_FROZEN));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic rd(input int sel, output logic [31:0] d);
    rd_req = 1'b1;
    rd_sel = SEL_W'(sel);
    tick();
    rd_req = 1'b0;
    d = 32'(rd_data);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; clr = 1'b0; halt = 1'b0; evt = '0; rd_req = 1'b0; rd_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_frozen", 32'(frozen), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
  endtask

  logic [31:0] d;

  initial begin
    model_clear();
    do_reset();

    // Plan 1: evt=0x05 for 10 COUNT cycles after one idle COUNT cycle
    en = 1'b1; tick();
    tick();
    evt = 8'h05;
    repeat (9) tick();
    en = 1'b0; tick();
    evt = '0;
    rd(0, d); chk("p1_ch0", d, 32'd10);
    rd(1, d); chk("p1_ch1", d, 32'd0);
    rd(2, d); chk("p1_ch2", d, 32'd10);
    rd(8, d); chk("p1_cyc", d, 32'd11);

    // Plan 5: out-of-range select and back-to-back reads
    rd(31, d); chk("p5_data", d, 32'd0); chk("p5_err", 32'(rd_err), 32'd1);
    rd(0, d); chk("p5_v0", 32'(rd_valid), 32'd1);
    rd(1, d); chk("p5_v1", 32'(rd_valid), 32'd1);
    rd(2, d); chk("p5_v2", 32'(rd_valid), 32'd1);
    tick(); chk("p5_idle", 32'(rd_valid), 32'd0);

    // Plan 2: channel 3 saturation
    do_clr();
    en = 1'b1; tick();
    evt = 8'h08;
    repeat (300) tick();
    evt = '0; en = 1'b0; tick();
    rd(3, d); chk("p2_ch3", d, 32'd255);
    chk("p2_ovf", 32'(ovf), 32'h08);
    rd(9, d); chk("p2_ovfmask", d, 32'h08);

    // Cycle-counter saturation without a flag
    do_clr();
    en = 1'b1;
    repeat (1100) tick();
    rd(8, d); chk("cyc_sat", d, 32'd1023);
    chk("cyc_noflag", 32'(ovf), 32'h00);
    en = 1'b0; tick();

    // Plan 4: clr coincident with events and a read
    do_clr();
    en = 1'b1; tick();
    evt = 8'h01;
    repeat (7) tick();
    evt = '0; en = 1'b0; tick();
    clr = 1'b1; evt = 8'hFF;
    rd(0, d); chk("p4_old", d, 32'd7);
    clr = 1'b0; evt = '0;
    rd(0, d); chk("p4_new", d, 32'd0);

    // Plan 3: halt counts its own cycle, then freezes
    en = 1'b1; tick();
    tick();
    evt = 8'h01; halt = 1'b1; tick();
    evt = '0; halt = 1'b0;
    chk("p3_frozen", 32'(frozen), 32'd1);
    repeat (20) begin
      evt = 8'($urandom);
      en = 1'($urandom);
      tick();
    end
    evt = '0; en = 1'b0;
    rd(0, d); chk("p3_ch0", d, 32'd1);
    rd(8, d); chk("p3_cyc", d, 32'd2);
    do_clr();
    chk("p3_unfrozen", 32'(frozen), 32'd0);
    for (int s = 0; s < NUM_CH + 2; s++) begin
      rd(s, d); chk("p3_zero", d, 32'd0);
    end

    // Randomized phase
    for (int n = 0; n < 2000; n++) begin
      en     = ($urandom_range(0, 7) != 0);
      evt    = 8'($urandom);
      halt   = ($urandom_range(0, 49) == 0);
      clr    = ($urandom_range(0, 39) == 0);
      rd_req = 1'($urandom);
      rd_sel = SEL_W'($urandom_range(0, 31));
      tick();
    end
    en = 1'b0; evt = '0; halt = 1'b0; clr = 1'b0; rd_req = 1'b0;
    tick();

    // Plan 6: asynchronous reset with a read response in flight
    do_clr();
    en = 1'b1; tick();
    evt = 8'h03;
    repeat (5) tick();
    rd_req = 1'b1; rd_sel = '0;
    @(posedge clk);
    #1;
    chk("p6_inflight", 32'(rd_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("p6_valid", 32'(rd_valid), 32'd0);
    chk("p6_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    model_clear();
    rd_req = 1'b0; en = 1'b0; evt = '0;
    chk("p6_frozen", 32'(frozen), 32'd0);
    rst_n = 1'b1;
    rd(0, d); chk("p6_ch0", d, 32'd0);
    rd(1, d); chk("p6_ch1", d, 32'd0);
    rd(8, d); chk("p6_cyc", d, 32'd0);
    en = 1'b1; tick();
    evt = 8'h01; tick();
    evt = '0; en = 1'b0; tick();
    rd(0, d); chk("p6_idle_start", d, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
